pn_frame_gen: RTL and testbench
===============================

# pn_frame_gen

Parametrised serial test-pattern source for the digital-telecom lab designs. It replaces the fixed single-bit user stub with a configurable pseudo-noise (m-sequence) generator. The generator has a programmable bit-rate divider and an optional framed mode that prefixes every payload with a sync word. It drives the board's serial test line (`bb`) and the strobes that downstream scramblers, encoders and BER checkers consume.

## Interface
Parameters:
- `LFSR_W`, 7, LFSR length in bits (3..16).
- `TAPS`, 7'h60, feedback mask; bit i set means state bit i feeds the XOR (default x^7+x^6+1).
- `DIV`, 50, clock cycles per output bit (≥2).
- `SYNC_W`, 8, sync word length.
- `SYNC_WORD`, 8'hE4, sync pattern, sent MSB first.
- `PAYLOAD_LEN`, 127, PN bits per frame (≥1).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `en`  in  1  run enable; low freezes divider, FSM and LFSR.
- `mode`  in  1  0 selects raw continuous m-sequence; 1 selects framed (sync + payload).
- `seed_load`  in  1  one-cycle request to load `seed`.
- `seed`  in  LFSR_W  LFSR seed; 0 is replaced by all-ones.
- `bb`  out  1  serial data bit, registered.
- `bit_stb`  out  1  one-cycle pulse marking each new `bb` value.
- `frame_start`  out  1  one-cycle pulse coincident with the first sync bit.
- `in_sync`  out  1  high while `bb` carries sync-word bits.

## Operation
- Divider `cnt` runs 0..DIV-1 and advances only when `en`=1. A tick occurs when `cnt`=DIV-1 and `en`=1; `cnt` then wraps to 0.
- Each tick registers the next bit into `bb` and pulses `bit_stb` on the following cycle.
- LFSR (Fibonacci): output = `s[LFSR_W-1]`; fb = XOR-reduce(`s & TAPS`); next = {`s[LFSR_W-2:0]`, fb}. It advances only on ticks in which a payload/raw bit is emitted.
- `seed_reg` holds the last loaded seed; reset value is all-ones.
- FSM states:
  - IDLE: after reset; on the first tick, go to SYNC if `mode`=1, else RAW.
  - SYNC: emit `SYNC_WORD` MSB first for SYNC_W ticks. The first tick reloads the LFSR from `seed_reg` and raises `frame_start`. After the last sync bit, go to PAYLOAD.
  - PAYLOAD: emit PAYLOAD_LEN LFSR bits, then go to SYNC if `mode`=1, else RAW.
  - RAW: emit LFSR bits indefinitely. `mode`=1 is sampled only when the tick counter `bitn` wraps mod PAYLOAD_LEN; on that wrap, go to SYNC.
- `mode` is sampled only at frame or period boundaries; mid-frame changes are ignored until the boundary.
- `seed_load` (any state, any `en`):
  - `seed_reg` and LFSR ← `seed`, or all-ones if `seed`=0.
  - `cnt` and `bitn` ← 0.
  - State ← SYNC if `mode`=1, else RAW.
  - It overrides a coincident tick; that tick is discarded and produces no `bit_stb`.
- `rst` overrides everything, including `seed_load`.

## Timing
- Reset values: `bb`=0, `bit_stb`=0, `frame_start`=0, `in_sync`=0, `cnt`=0, `bitn`=0, LFSR=`seed_reg`=all-ones, state IDLE.
- With `en` held high from the first cycle after reset, the first tick is the DIV-th enabled cycle. `bit_stb` and the new `bb` appear one cycle later. After that, `bit_stb` pulses every DIV enabled cycles.
- `frame_start` and `in_sync` are registered alongside `bb`, so they align exactly with `bit_stb`.
- `in_sync` stays high for SYNC_W consecutive bit periods.
- Dropping `en` stretches the current bit period. `bb` holds its value; no bit is lost or duplicated.
- Frame period in framed mode = (SYNC_W + PAYLOAD_LEN) × DIV enabled cycles.
- With `seed_load` asserted in cycle N, the first new bit follows DIV enabled cycles after N.

## Structure
- Shared package `pn_gen_pkg`:
  - FSM state encoding (IDLE, SYNC, PAYLOAD, RAW).
  - Default tap masks for LFSR_W 3..16.
  - Default sync word.
- One sub-module, `lfsr_core`, parametrised by LFSR_W and TAPS.
  - Inputs: `clk`, `rst`, `step`, `load`, `load_val`.
  - Output: `out_bit`.
  - Performs the zero-seed substitution internally.
- The top level contains the divider, the bit counter `bitn` (width $clog2(max(SYNC_W, PAYLOAD_LEN))), the FSM and the output registers.

## Test plan
- Raw mode, defaults, DIV=4, no seed load:
  - First 8 `bb` bits are 1,1,1,1,1,1,1,0.
  - Sequence repeats with period 127 bits, containing 64 ones.
- Divider: DIV=5, `en` toggled 1 cycle low every 3 cycles → `bit_stb` pulses once per 5 enabled cycles, and `bb` is stable between pulses.
- Framed mode, PAYLOAD_LEN=16, seed 7'h7F:
  - Each frame is E4 (1110_0100) then 1111_1110_0000_0100.
  - `frame_start` fires on the first sync bit; `in_sync` is high for exactly 8 bits.
  - Every frame is identical.
- `seed_load` with `seed`=0 mid-payload → the frame aborts and the next bit begins a fresh sync word. Payload restarts with seven 1s.
- `seed_load` coincident with a tick → no `bit_stb` on the following cycle; next pulse comes DIV enabled cycles after the load.
- `mode` 0→1 mid-period, then `rst` mid-frame:
  - Framing begins only at the 127-bit boundary.
  - After `rst`, all outputs are 0 and the state is IDLE the next cycle.

Source files
------------

// File: rtl/pn_gen_pkg.sv
// Shared definitions for the pseudo-noise frame generator: FSM encoding,
// maximal-length tap masks and the default sync pattern.
package pn_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_RAW     = 2'd3
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hE4;

  // Mask bit i feeds state bit i into the feedback XOR (x^n + ... + 1).
  function automatic logic [15:0] default_taps(input int unsigned w);
    logic [15:0] t;
    case (w)
      3:       t = 16'h0006;
      4:       t = 16'h000C;
      5:       t = 16'h0014;
      6:       t = 16'h0030;
      7:       t = 16'h0060;
      8:       t = 16'h00B8;
      9:       t = 16'h0110;
      10:      t = 16'h0240;
      11:      t = 16'h0500;
      12:      t = 16'h0829;
      13:      t = 16'h100D;
      14:      t = 16'h2015;
      15:      t = 16'h6000;
      16:      t = 16'hD008;
      default: t = 16'h0000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR: MSB is the output bit, feedback shifts in at the LSB.
// A zero load value is replaced by all-ones so the register never locks up.
module lfsr_core #(
  parameter int                LFSR_W = 7,
  parameter logic [LFSR_W-1:0] TAPS   = 7'h60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic              out_bit
);

  logic [LFSR_W-1:0] s;

  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '1;
    end else if (load) begin
      s <= (load_val == '0) ? '1 : load_val;
    end else if (step) begin
      s <= {s[LFSR_W-2:0], ^(s & TAPS)};
    end
  end

  assign out_bit = s[LFSR_W-1];

endmodule

// File: rtl/pn_frame_gen.sv
// Serial PN test-pattern source: bit-rate divider, raw or framed
// (sync word + payload) sequencing and registered serial outputs.
module pn_frame_gen
  import pn_gen_pkg::*;
#(
  parameter int                LFSR_W      = 7,
  parameter logic [LFSR_W-1:0] TAPS        = 7'h60,
  parameter int                DIV         = 50,
  parameter int                SYNC_W      = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD   = DEFAULT_SYNC_WORD,
  parameter int                PAYLOAD_LEN = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic              bb,
  output logic              bit_stb,
  output logic              frame_start,
  output logic              in_sync
);

  localparam int CNT_W    = $clog2(DIV);
  localparam int BITN_MAX = (SYNC_W > PAYLOAD_LEN) ? SYNC_W : PAYLOAD_LEN;
  localparam int BITN_W   = (BITN_MAX > 1) ? $clog2(BITN_MAX) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [BITN_W-1:0] SYNC_LAST = BITN_W'(SYNC_W - 1);
  localparam logic [BITN_W-1:0] PAY_LAST  = BITN_W'(PAYLOAD_LEN - 1);

  state_t              state, cur_state, next_state;
  logic [CNT_W-1:0]    cnt;
  logic [BITN_W-1:0]   bitn, bitn_nxt;
  logic [LFSR_W-1:0]   seed_reg;
  logic [SYNC_W-1:0]   sync_sh;
  logic                tick;
  logic                lfsr_out;
  logic                bit_p0, sync_p0, first_p0;
  logic                step_req, reload_req;

  lfsr_core #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .step     (tick && step_req && !seed_load),
    .load     (seed_load || (tick && reload_req)),
    .load_val (seed_load ? seed : seed_reg),
    .out_bit  (lfsr_out)
  );

  // Stage p0: decide the bit emitted on the coming tick and the next FSM state.
  always_comb begin
    tick       = en && (cnt == CNT_LAST);
    cur_state  = state;
    if (state == ST_IDLE) cur_state = mode ? ST_SYNC : ST_RAW;
    next_state = cur_state;
    bitn_nxt   = bitn + 1'b1;
    bit_p0     = bb;
    sync_p0    = in_sync;
    first_p0   = 1'b0;
    step_req   = 1'b0;
    reload_req = 1'b0;
    sync_sh    = SYNC_WORD << bitn;

    case (cur_state)
      ST_SYNC: begin
        bit_p0  = sync_sh[SYNC_W-1];
        sync_p0 = 1'b1;
        if (bitn == '0) begin
          first_p0   = 1'b1;
          reload_req = 1'b1;
        end
        if (bitn == SYNC_LAST) begin
          bitn_nxt   = '0;
          next_state = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        bit_p0   = lfsr_out;
        sync_p0  = 1'b0;
        step_req = 1'b1;
        if (bitn == PAY_LAST) begin
          bitn_nxt   = '0;
          next_state = mode ? ST_SYNC : ST_RAW;
        end
      end
      ST_RAW: begin
        bit_p0   = lfsr_out;
        sync_p0  = 1'b0;
        step_req = 1'b1;
        // Framing can only start on a whole-period boundary.
        if (bitn == PAY_LAST) begin
          bitn_nxt   = '0;
          next_state = mode ? ST_SYNC : ST_RAW;
        end
      end
      default: ;
    endcase
  end

  // Stage p1: registered outputs, all aligned with bit_stb.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bitn        <= '0;
      seed_reg    <= '1;
      bb          <= 1'b0;
      bit_stb     <= 1'b0;
      frame_start <= 1'b0;
      in_sync     <= 1'b0;
    end else if (seed_load) begin
      seed_reg    <= (seed == '0) ? '1 : seed;
      cnt         <= '0;
      bitn        <= '0;
      state       <= mode ? ST_SYNC : ST_RAW;
      bit_stb     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      bit_stb     <= tick;
      frame_start <= tick && first_p0;
      if (en) cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        state   <= next_state;
        bitn    <= bitn_nxt;
        bb      <= bit_p0;
        in_sync <= sync_p0;
      end
    end
  end

endmodule

// File: tb/tb_pn_frame_gen.sv
// Directed bench for pn_frame_gen: three instances share the stimulus
// (raw DIV=4, raw DIV=5, framed DIV=4 with a 16-bit payload).
module tb_pn_frame_gen;

  logic       clk = 1'b0;
  logic       rst, en, mode, seed_load;
  logic [6:0] seed;
  logic       bb_a [3];
  logic       stb_a[3];
  logic       fs_a [3];
  logic       sy_a [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pn_frame_gen #(.DIV(4)) dut_raw (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .seed_load(seed_load), .seed(seed),
    .bb(bb_a[0]), .bit_stb(stb_a[0]), .frame_start(fs_a[0]), .in_sync(sy_a[0]));

  pn_frame_gen #(.DIV(5)) dut_div (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .seed_load(seed_load), .seed(seed),
    .bb(bb_a[1]), .bit_stb(stb_a[1]), .frame_start(fs_a[1]), .in_sync(sy_a[1]));

  pn_frame_gen #(.DIV(4), .PAYLOAD_LEN(16)) dut_frm (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .seed_load(seed_load), .seed(seed),
    .bb(bb_a[2]), .bit_stb(stb_a[2]), .frame_start(fs_a[2]), .in_sync(sy_a[2]));

  typedef struct {
    logic mode;
    logic bb;
    logic sync;
    logic fs;
  } vec_t;

  vec_t raw_tab[8];
  vec_t frm_tab[24];
  logic ref_bits[127];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_stb(input int k, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!stb_a[k] && n < 200);
    if (n >= 200) check($sformatf("stb_timeout_%0d", k), 32'(stb_a[k]), 1);
  endtask

  task automatic apply_vec(input int k, input vec_t v, input string tag, input int idx,
                           output int n);
    mode = v.mode;
    wait_stb(k, n);
    check($sformatf("%s[%0d].bb", tag, idx),   32'(bb_a[k]), 32'(v.bb));
    check($sformatf("%s[%0d].sync", tag, idx), 32'(sy_a[k]), 32'(v.sync));
    check($sformatf("%s[%0d].fs", tag, idx),   32'(fs_a[k]), 32'(v.fs));
  endtask

  task automatic do_reset(input logic m);
    rst       = 1'b1;
    en        = 1'b0;
    seed_load = 1'b0;
    seed      = '0;
    mode      = m;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int   n, ones, mism, sync_seen, lat_bad;
    int   e, stb_bad, hold_bad, bit_bad, pulses, exp_pulses;
    logic exp_stb, last_bb;
    logic [7:0]  sw;
    logic [15:0] pay;
    logic [7:0]  raw8;

    raw8 = 8'b1111_1110;
    sw   = 8'hE4;
    pay  = 16'b1111_1110_0000_0100;
    for (int i = 0; i < 8; i++) raw_tab[i] = '{1'b0, raw8[7-i], 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) frm_tab[i] = '{1'b1, sw[7-i], 1'b1, (i == 0)};
    for (int i = 0; i < 16; i++) frm_tab[8+i] = '{1'b1, pay[15-i], 1'b0, 1'b0};

    // Reset state and raw m-sequence from the default all-ones seed
    do_reset(1'b0);
    check("reset_outs", 32'({bb_a[0], stb_a[0], fs_a[0], sy_a[0]}), 0);
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      apply_vec(0, raw_tab[i], "raw", i, n);
      check($sformatf("raw_spacing[%0d]", i), n, 4);
      ref_bits[i] = bb_a[0];
    end
    for (int i = 8; i < 127; i++) begin
      wait_stb(0, n);
      ref_bits[i] = bb_a[0];
    end
    ones = 0;
    for (int i = 0; i < 127; i++) if (ref_bits[i]) ones++;
    check("raw_ones", ones, 64);
    mism = 0;
    sync_seen = 0;
    for (int i = 0; i < 127; i++) begin
      wait_stb(0, n);
      if (bb_a[0] !== ref_bits[i]) mism++;
      if (sy_a[0] !== 1'b0) sync_seen++;
    end
    check("raw_repeat", mism, 0);
    check("raw_no_sync", sync_seen, 0);

    // seed_load on the very cycle of a tick: that tick is dropped
    repeat (3) @(negedge clk);
    seed      = 7'h7F;
    seed_load = 1'b1;
    @(negedge clk);
    check("coinc_no_stb", 32'(stb_a[0]), 0);
    seed_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      apply_vec(0, raw_tab[i], "coinc", i, n);
      if (i == 0) check("coinc_latency", n, 4);
    end

    // Divider with en low one cycle in three
    do_reset(1'b0);
    e = 0; stb_bad = 0; hold_bad = 0; bit_bad = 0; pulses = 0; exp_pulses = 0;
    last_bb = bb_a[1];
    for (int i = 0; i < 90; i++) begin
      en = (i % 3 != 2);
      if (en) e++;
      exp_stb = en && (e % 5 == 0);
      if (exp_stb) exp_pulses++;
      @(negedge clk);
      if (stb_a[1] !== exp_stb) stb_bad++;
      if (stb_a[1] === 1'b1) begin
        if (pulses < 127 && bb_a[1] !== ref_bits[pulses]) bit_bad++;
        pulses++;
      end else if (bb_a[1] !== last_bb) begin
        hold_bad++;
      end
      last_bb = bb_a[1];
    end
    check("div_stb_timing", stb_bad, 0);
    check("div_bb_hold", hold_bad, 0);
    check("div_bits", bit_bad, 0);
    check("div_pulses", pulses, exp_pulses);

    // Framed mode, three identical frames after an explicit seed load
    do_reset(1'b1);
    seed      = 7'h7F;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    en        = 1'b1;
    lat_bad   = 0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 24; i++) begin
        apply_vec(2, frm_tab[i], $sformatf("frame%0d", f), i, n);
        if (n != 4) lat_bad++;
      end
    check("frm_spacing", lat_bad, 0);

    // Zero seed loaded mid-payload aborts the frame and restarts sync
    for (int i = 0; i < 13; i++) apply_vec(2, frm_tab[i], "pre_abort", i, n);
    seed      = '0;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    for (int i = 0; i < 24; i++) begin
      apply_vec(2, frm_tab[i], "abort", i, n);
      if (i == 0) check("abort_latency", n, 4);
    end

    // mode 0->1 mid-period waits for the 127-bit boundary, then reset mid-frame
    do_reset(1'b0);
    en = 1'b1;
    mism = 0;
    sync_seen = 0;
    for (int i = 0; i < 127; i++) begin
      if (i == 50) mode = 1'b1;
      wait_stb(0, n);
      if (bb_a[0] !== ref_bits[i]) mism++;
      if (sy_a[0] !== 1'b0 || fs_a[0] !== 1'b0) sync_seen++;
    end
    check("switch_raw_bits", mism, 0);
    check("switch_no_early_sync", sync_seen, 0);
    for (int i = 0; i < 11; i++) apply_vec(0, frm_tab[i], "switch", i, n);
    rst = 1'b1;
    @(negedge clk);
    check("rst_outs", 32'({bb_a[0], stb_a[0], fs_a[0], sy_a[0]}), 0);
    rst = 1'b0;
    apply_vec(0, frm_tab[0], "post_rst", 0, n);
    check("post_rst_latency", n, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
